// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader.
package boot_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } boot_state_t;

  // The header and every payload word are both four bytes long. That is why
  // a single assembler, with its 2-bit wrapping counter, can frame both.
  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word shifter with a wrapping 2-bit byte counter.
// word_out is the word as it stands once the byte on byte_in is included.
// It is therefore the complete word in the cycle that word_full is high.
module word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  logic [31:0] shift_q;
  logic [1:0]  cnt_q;

  // Newest byte enters at the top, so the first byte received ends up in bits [7:0].
  assign word_out  = {byte_in, shift_q[31:8]};
  assign word_full = load && (cnt_q == 2'(WORD_BYTES - 1));

  // Shift in one byte per load; the counter wraps 3->0 at each word boundary.
  always_ff @(posedge clk) begin
    if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= word_out;
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Byte-stream program loader. It frames a header/payload/checksum image,
// writes the payload words into core memory, and releases the core from reset
// only after a verified load.
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        core_reset_n,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  boot_state_t      state, state_next;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] word_cnt;
  logic [7:0]       sum;

  logic             take;
  logic             asm_load;
  logic [31:0]      asm_word;
  logic             asm_full;
  logic             hdr_bad;
  logic             last_word;

  // Ready is a pure state decode. It is gated by reset_n so that no byte can
  // be taken on an edge that is resetting the loader.
  assign rx_ready = reset_n && ((state == HDR) || (state == DATA) || (state == CSUM));
  assign take     = rx_valid && rx_ready;
  assign asm_load = take && ((state == HDR) || (state == DATA));

  // The count check uses all 32 header bits, so a count with upper bits set is rejected.
  assign hdr_bad   = (asm_word == 32'd0) || (asm_word > 32'(MAX_WORDS));
  assign last_word = (IDX_W'(word_idx + 1'b1) == word_cnt);

  word_assembler u_asm (
    .clk       (clk),
    .clear     (!reset_n),
    .load      (asm_load),
    .byte_in   (rx_data),
    .word_out  (asm_word),
    .word_full (asm_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= HDR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (asm_full) begin
          state_next = hdr_bad ? ERR : DATA;
        end
      end
      DATA: begin
        if (asm_full) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = last_word ? CSUM : DATA;
      end
      CSUM: begin
        if (take) begin
          state_next = (rx_data == sum) ? DONE : ERR;
        end
      end
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  // Word count latch, word index and running payload checksum.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_cnt <= '0;
      word_idx <= '0;
      sum      <= '0;
    end else begin
      if ((state == HDR) && asm_full && !hdr_bad) begin
        word_cnt <= asm_word[IDX_W-1:0];
      end
      if ((state == DATA) && take) begin
        sum <= sum + rx_data;
      end
      if (state == WRITE) begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

  // Memory write port. The outputs are registered on the edge that completes a
  // word, so the strobe is high for the WRITE cycle and address/data hold after it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_write      <= 1'b0;
      mem_address    <= BASE_ADDR;
      mem_write_data <= '0;
    end else begin
      mem_write <= (state == DATA) && asm_full;
      if ((state == DATA) && asm_full) begin
        mem_address    <= BASE_ADDR + 32'({word_idx, 2'b00});
        mem_write_data <= asm_word;
      end
    end
  end

  // Status outputs are flops fed from the next state, so they change cleanly
  // on the edge that enters DONE or ERR.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      core_reset_n <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      core_reset_n <= (state_next == DONE);
      done         <= (state_next == DONE);
      error        <= (state_next == ERR);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Randomised scoreboard bench for boot_loader. The driver pushes the writes that the
// image should produce; a monitor pops and compares them as the DUT emits them.
module tb_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        sel;

  logic        r0, r1, mw0, mw1, crn0, crn1, d0, d1, e0, e1;
  logic [31:0] ma0, ma1, md0, md1;

  boot_loader dut0 (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid && !sel), .rx_data(rx_data),
    .rx_ready(r0), .mem_write(mw0), .mem_address(ma0), .mem_write_data(md0),
    .core_reset_n(crn0), .done(d0), .error(e0)
  );

  boot_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid && sel), .rx_data(rx_data),
    .rx_ready(r1), .mem_write(mw1), .mem_address(ma1), .mem_write_data(md1),
    .core_reset_n(crn1), .done(d1), .error(e1)
  );

  logic        rx_ready, mem_write, core_reset_n, done, error;
  logic [31:0] mem_address, mem_write_data;
  assign rx_ready       = sel ? r1   : r0;
  assign mem_write      = sel ? mw1  : mw0;
  assign mem_address    = sel ? ma1  : ma0;
  assign mem_write_data = sel ? md1  : md0;
  assign core_reset_n   = sel ? crn1 : crn0;
  assign done           = sel ? d1   : d0;
  assign error          = sel ? e1   : e0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] img[$];
  logic [31:0] mon_a, mon_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on each write strobe, plus the ready-low rule.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_write) begin
        check("wr_ready_low", {31'd0, rx_ready}, 32'd0);
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", mem_address, 32'hFFFF_FFFF);
        end else begin
          mon_a = exp_addr_q.pop_front();
          mon_d = exp_data_q.pop_front();
          check("wr_addr", mem_address, mon_a);
          check("wr_data", mem_write_data, mon_d);
        end
      end
      if (!rx_ready) begin
        check("ready_low_only_write_or_final", {31'd0, mem_write || done || error}, 32'd1);
      end
    end
  end

  function automatic logic [7:0] img_sum();
    logic [7:0] s = 8'd0;
    foreach (img[i]) for (int k = 0; k < 4; k++) s = s + 8'((img[i] >> (8 * k)) & 32'hFF);
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int waited = 0;
    if (stall && ($urandom_range(0, 2) == 0)) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    logic [31:0] base;
    base = sel ? 32'h0000_0100 : 32'h0;
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",     {31'd0, rx_ready},     32'd0);
    check("rst_mem_write", {31'd0, mem_write},    32'd0);
    check("rst_addr",      mem_address,           base);
    check("rst_wdata",     mem_write_data,        32'd0);
    check("rst_core_rst",  {31'd0, core_reset_n}, 32'd0);
    check("rst_done",      {31'd0, done},         32'd0);
    check("rst_error",     {31'd0, error},        32'd0);
    reset_n = 1'b1;
    t0 = cyc;
    #1;
    check("rel_ready", {31'd0, rx_ready}, 32'd1);
  endtask

  // Drives one image taken from img[] with the given header and checksum, and
  // checks the outcome that the stream format predicts.
  task automatic run_image(input logic [31:0] hdr, input logic [7:0] csum,
                           input bit stall, input bit timed);
    int          max_w;
    logic [31:0] base;
    bit          bad_n;
    bit          ok;
    max_w = sel ? 8 : 256;
    base  = sel ? 32'h0000_0100 : 32'h0;
    bad_n = (hdr == 32'd0) || (hdr > 32'(max_w));
    if (!bad_n) begin
      foreach (img[i]) begin
        exp_addr_q.push_back(base + 32'(4 * i));
        exp_data_q.push_back(img[i]);
      end
    end
    for (int k = 0; k < 4; k++) send_byte(8'((hdr >> (8 * k)) & 32'hFF), stall);
    if (bad_n) begin
      rx_valid = 1'b0;
      check("badn_error",   {31'd0, error},        32'd1);
      check("badn_core",    {31'd0, core_reset_n}, 32'd0);
      repeat (3) @(negedge clk);
      check("badn_error_held", {31'd0, error}, 32'd1);
      check("badn_done",    {31'd0, done},         32'd0);
      return;
    end
    foreach (img[i]) for (int k = 0; k < 4; k++) send_byte(8'((img[i] >> (8 * k)) & 32'hFF), stall);
    send_byte(csum, stall);
    rx_valid = 1'b0;
    ok = (csum == img_sum());
    if (timed) begin
      check("load_cycles", 32'(cyc - t0), 32'(4 + 5 * img.size() + 1));
      check("timed_done",  {31'd0, done}, {31'd0, ok});
    end
    repeat (2) @(negedge clk);
    check("final_done",  {31'd0, done},         {31'd0, ok});
    check("final_error", {31'd0, error},        {31'd0, !ok});
    check("final_core",  {31'd0, core_reset_n}, {31'd0, ok});
    check("all_writes_seen", 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    int         n;
    sel      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset_n  = 1'b0;

    // Nominal load, continuous valid, cycle-exact completion.
    do_reset();
    img = '{32'h0000_0013, 32'h0050_0093};
    run_image(32'd2, 8'hF6, 1'b0, 1'b1);

    // Same image with source stalls.
    do_reset();
    run_image(32'd2, 8'hF6, 1'b1, 1'b0);

    // Bad checksum.
    do_reset();
    run_image(32'd2, 8'hF5, 1'b0, 1'b0);

    // Bad counts.
    do_reset();
    run_image(32'd0, 8'h00, 1'b0, 1'b0);
    do_reset();
    run_image(32'd257, 8'h00, 1'b0, 1'b0);
    do_reset();
    run_image(32'h0001_0001, 8'h00, 1'b0, 1'b0);

    // Reset during the third payload byte, then a full nominal load.
    do_reset();
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    reset_n  = 1'b0;
    #1;
    check("midrst_ready", {31'd0, rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_mem_write", {31'd0, mem_write},    32'd0);
    check("midrst_addr",      mem_address,           32'd0);
    check("midrst_wdata",     mem_write_data,        32'd0);
    check("midrst_core",      {31'd0, core_reset_n}, 32'd0);
    check("midrst_done",      {31'd0, done},         32'd0);
    check("midrst_error",     {31'd0, error},        32'd0);
    rx_valid = 1'b0;
    reset_n  = 1'b1;
    t0 = cyc;
    run_image(32'd2, 8'hF6, 1'b0, 1'b1);

    // Randomised images, some with corrupted checksums.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      n = $urandom_range(1, 5);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      s = img_sum();
      if ($urandom_range(0, 2) == 0) s = s + 8'($urandom_range(1, 255));
      run_image(32'(n), s, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Offset base address with a full-size image on the second instance.
    sel = 1'b1;
    do_reset();
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back($urandom);
    run_image(32'd8, img_sum(), 1'b0, 1'b1);
    do_reset();
    run_image(32'd9, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
